// File: rtl/decoder_controller.sv
// decoder_controller: RV32I main control decode; define DECODER_CTRL_REG_OUT_EN to register outputs.
module decoder_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       reg_write,
    output logic [2:0] wb_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       use_pc_as_alu_a,
    output logic       mem_read,
    output logic       mem_write,
    output logic       branch,
    output logic       jump,
    output logic       jalr,
    output logic       illegal_instr
);
    // ctl = {reg_write, wb_sel, alu_src, alu_op, use_pc_as_alu_a, mem_read, mem_write, branch, jump, jalr}
    logic [12:0] ctl;
    logic        bad;
    logic [13:0] nxt, q;

    always_comb begin
        ctl = '0;
        bad = 1'b0;
        case (opcode)
            7'b0110011: begin
                ctl = 13'b1_000_0_10_0_0_0_0_0_0;
                bad = (funct7 != 7'b0000000 && funct7 != 7'b0100000) ||
                      (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101);
            end
            7'b0010011: begin
                ctl = 13'b1_000_1_11_0_0_0_0_0_0;
                bad = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
                      (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000);
            end
            7'b0000011: begin
                ctl = 13'b1_001_1_00_0_1_0_0_0_0;
                bad = funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111;
            end
            7'b0100011: begin
                ctl = 13'b0_000_1_00_0_0_1_0_0_0;
                bad = funct3 > 3'b010;
            end
            7'b1100011: begin
                ctl = 13'b0_000_0_01_0_0_0_1_0_0;
                bad = funct3 == 3'b010 || funct3 == 3'b011;
            end
            7'b1101111: ctl = 13'b1_010_0_00_0_0_0_0_1_0;
            7'b1100111: begin
                ctl = 13'b1_010_1_00_0_0_0_0_0_1;
                bad = funct3 != 3'b000;
            end
            7'b0110111: ctl = 13'b1_011_0_00_0_0_0_0_0_0;
            7'b0010111: ctl = 13'b1_100_1_00_1_0_0_0_0_0;
            default:    bad = 1'b1;
        endcase
    end

    assign nxt = bad ? 14'd1 : {ctl, 1'b0};

`ifdef DECODER_CTRL_REG_OUT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else        q <= nxt;
`else
    logic unused_clk;
    assign unused_clk = clk;
    assign q = rst_n ? nxt : '0;
`endif

    assign {reg_write, wb_sel, alu_src, alu_op, use_pc_as_alu_a,
            mem_read, mem_write, branch, jump, jalr, illegal_instr} = q;
endmodule

// File: tb/tb_decoder_controller.sv
// tb_decoder_controller: directed vector check of decoder_controller in either build mode.
module tb_decoder_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       reg_write, alu_src, use_pc_as_alu_a, mem_read, mem_write, branch, jump, jalr, illegal_instr;
    logic [2:0] wb_sel;
    logic [1:0] alu_op;
    int         n_vec = 0;
    int         n_bad = 0;

    decoder_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
        .use_pc_as_alu_a(use_pc_as_alu_a), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .jalr(jalr), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
                           BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
                           LUI = 7'b0110111, AUI = 7'b0010111;
    // expected = {reg_write, wb_sel, alu_src, alu_op, use_pc, mem_read, mem_write, branch, jump, jalr, illegal}
    localparam logic [13:0] R_OP   = 14'b1_000_0_10_0_0_0_0_0_0_0,
                            R_OPI  = 14'b1_000_1_11_0_0_0_0_0_0_0,
                            R_LD   = 14'b1_001_1_00_0_1_0_0_0_0_0,
                            R_ST   = 14'b0_000_1_00_0_0_1_0_0_0_0,
                            R_BR   = 14'b0_000_0_01_0_0_0_1_0_0_0,
                            R_JAL  = 14'b1_010_0_00_0_0_0_0_1_0_0,
                            R_JALR = 14'b1_010_1_00_0_0_0_0_0_1_0,
                            R_LUI  = 14'b1_011_0_00_0_0_0_0_0_0_0,
                            R_AUI  = 14'b1_100_1_00_1_0_0_0_0_0_0,
                            ILL    = 14'b0_000_0_00_0_0_0_0_0_0_1,
                            ZERO   = 14'b0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [13:0] exp;
    } vec_t;
    vec_t vq[$];

    function automatic logic [13:0] got();
        return {reg_write, wb_sel, alu_src, alu_op, use_pc_as_alu_a,
                mem_read, mem_write, branch, jump, jalr, illegal_instr};
    endfunction

    task automatic chk(input string name, input logic [13:0] exp);
        n_vec++;
        if (got() !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got(), exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    initial begin
        vq = '{
            '{OP,   3'b000, 7'h00, R_OP},
            '{OPI,  3'b000, 7'h00, R_OPI},
            '{LD,   3'b010, 7'h00, R_LD},
            '{ST,   3'b010, 7'h00, R_ST},
            '{BR,   3'b000, 7'h00, R_BR},
            '{JAL,  3'b000, 7'h00, R_JAL},
            '{JALR, 3'b000, 7'h00, R_JALR},
            '{LUI,  3'b000, 7'h00, R_LUI},
            '{AUI,  3'b000, 7'h00, R_AUI},
            '{7'h7F, 3'b111, 7'h7F, ILL},
            '{JALR, 3'b001, 7'h00, ILL},
            '{OP,   3'b001, 7'h20, ILL},
            '{BR,   3'b010, 7'h00, ILL},
            '{BR,   3'b011, 7'h00, ILL},
            '{OP,   3'b000, 7'h20, R_OP},
            '{OP,   3'b101, 7'h20, R_OP},
            '{OP,   3'b000, 7'h01, ILL},
            '{OPI,  3'b101, 7'h20, R_OPI},
            '{OPI,  3'b101, 7'h10, ILL},
            '{OPI,  3'b001, 7'h20, ILL},
            '{OPI,  3'b000, 7'h7F, R_OPI},
            '{ST,   3'b011, 7'h00, ILL},
            '{ST,   3'b000, 7'h00, R_ST},
            '{LD,   3'b110, 7'h00, ILL},
            '{LD,   3'b101, 7'h00, R_LD},
            '{LD,   3'b011, 7'h00, ILL},
            '{BR,   3'b111, 7'h55, R_BR},
            '{JAL,  3'b111, 7'h7F, R_JAL},
            '{LUI,  3'b101, 7'h3C, R_LUI},
            '{7'h00, 3'b000, 7'h00, ILL}
        };
        drive(LD, 3'b010, 7'h00);
        #1 chk("reset_state", ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].op, vq[i].f3, vq[i].f7);
            @(posedge clk);
            #1 chk($sformatf("vec%0d op=%b f3=%b f7=%b", i, vq[i].op, vq[i].f3, vq[i].f7), vq[i].exp);
        end

        // async reset while LOAD is held, then release
        @(negedge clk);
        drive(LD, 3'b010, 7'h00);
        @(posedge clk);
        #1 chk("load_before_reset", R_LD);
        rst_n = 1'b0;
        #0 chk("reset_same_step", ZERO);
        #1 chk("reset_held", ZERO);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DECODER_CTRL_REG_OUT_EN
        #1 chk("after_release_before_edge", ZERO);
`else
        #1 chk("after_release_comb", R_LD);
`endif
        @(posedge clk);
        #1 chk("after_release_edge", R_LD);

        // input change between edges
        @(negedge clk);
        drive(OP, 3'b000, 7'h00);
        @(posedge clk);
        #1 chk("op_row", R_OP);
        @(negedge clk);
        drive(ST, 3'b010, 7'h00);
`ifdef DECODER_CTRL_REG_OUT_EN
        #1 chk("hold_op_until_edge", R_OP);
`else
        #1 chk("store_immediate", R_ST);
`endif
        @(posedge clk);
        #1 chk("store_row", R_ST);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
